// File: rtl/register_pkg.sv
// Shared constants and types for the loadable / auto-incrementing register.
// Instantiators use XLEN and PC_STEP to build a program counter.
package register_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  // Which source feeds the flop bank on the next rising edge.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_INC  = 2'd1,
    SEL_LOAD = 2'd2
  } next_sel_e;

endpackage

// File: rtl/register_if.sv
// Control/data bundle of the register: per-cycle load/inc enables, load data and contents.
// There is no valid/ready pair: load and inc are sampled on every rising edge, and out is always valid.
interface register_if #(
  parameter int size = register_pkg::XLEN
);

  logic            inc;
  logic            load;
  logic [size-1:0] in;
  logic [size-1:0] out;

  modport master (output inc, load, in, input out);
  modport slave  (input inc, load, in, output out);

endinterface

// File: rtl/register_reg_incrementer.sv
// Combinational size-bit add of a constant step; the carry out is discarded.
module reg_incrementer #(
  parameter int size              = 32,
  parameter int default_increment = 4
) (
  input  logic [size-1:0] a,
  output logic [size-1:0] sum
);

  // The step is cut to size bits so narrow instances still wrap modulo 2^size.
  localparam logic [size-1:0] STEP = size'(default_increment);

  assign sum = a + STEP;

endmodule

// File: rtl/register.sv
// Edge-triggered register with parallel load (highest priority), constant-step increment
// and hold; asynchronous active-low reset to reset_value.
module register
  import register_pkg::*;
#(
  parameter int              size              = XLEN,
  parameter int              default_increment = PC_STEP,
  parameter logic [size-1:0] reset_value       = '0
) (
  input logic       clock,
  input logic       reset_n,
  register_if.slave bus
);

  logic [size-1:0] value_q;
  logic [size-1:0] value_inc;
  logic [size-1:0] value_d;
  next_sel_e       sel;

  reg_incrementer #(
    .size              (size),
    .default_increment (default_increment)
  ) u_incrementer (
    .a   (value_q),
    .sum (value_inc)
  );

  always_comb begin
    sel = SEL_HOLD;
    if (bus.load)
      sel = SEL_LOAD;
    else if (bus.inc)
      sel = SEL_INC;
  end

  always_comb begin
    value_d = value_q;
    unique case (sel)
      SEL_LOAD: value_d = bus.in;
      SEL_INC:  value_d = value_inc;
      default:  value_d = value_q;
    endcase
  end

  // Reset assertion clears the contents immediately; release waits for the next edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      value_q <= reset_value;
    else
      value_q <= value_d;
  end

  assign bus.out = value_q;

endmodule

// File: tb/tb_register.sv
// Self-checking bench for register: directed scenarios plus randomized load/inc/hold traffic
// compared against an arithmetic reference model through an expected-value queue.
module tb_register;
  import register_pkg::*;

  localparam int W = XLEN;

  logic clock;
  logic reset_n;

  register_if #(.size(W)) bus ();

  register #(
    .size              (W),
    .default_increment (PC_STEP),
    .reset_value       ('0)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_value;
  int           checks_total;
  int           checks_passed;

  task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] required);
    checks_total++;
    if (actual === required)
      checks_passed++;
    else
      $display("FAIL %s: got %h, expected %h", name, actual, required);
  endtask

  // Monitor: the register shows its new contents one edge after each driven cycle.
  initial begin
    logic [W-1:0] exp_val;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp_val = exp_q.pop_front();
        check("out_after_edge", bus.out, exp_val);
      end
    end
  end

  // Reference rule: load takes in, else inc adds the step modulo 2^W, else hold.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input logic ld,
                                              input logic ic, input logic [W-1:0] din);
    longint unsigned sum;
    if (ld) return din;
    if (ic) begin
      sum = longint'(cur) + longint'(PC_STEP);
      return W'(sum % (longint'(1) << W));
    end
    return cur;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic ld, input logic ic, input logic [W-1:0] din);
    @(negedge clock);
    bus.load    = ld;
    bus.inc     = ic;
    bus.in      = din;
    model_value = model_next(model_value, ld, ic, din);
    exp_q.push_back(model_value);
  endtask

  // Directed step with the expected value written out explicitly.
  task automatic drive_expect(input logic ld, input logic ic, input logic [W-1:0] din,
                              input logic [W-1:0] required);
    @(negedge clock);
    bus.load    = ld;
    bus.inc     = ic;
    bus.in      = din;
    model_value = required;
    exp_q.push_back(required);
  endtask

  task automatic drain(input int budget);
    int waited;
    waited = 0;
    while (exp_q.size() > 0 && waited < budget) begin
      @(posedge clock);
      #2;
      waited++;
    end
    checks_total++;
    if (exp_q.size() == 0)
      checks_passed++;
    else begin
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic         ld;
    logic         ic;
    logic [W-1:0] din;

    checks_total  = 0;
    checks_passed = 0;
    model_value   = '0;
    bus.load      = 1'b0;
    bus.inc       = 1'b0;
    bus.in        = 32'hDEAD_BEEF;
    reset_n       = 1'b1;

    // 1. async reset with no clock edge, then release with load of zero
    #1;
    reset_n  = 1'b0;
    bus.load = 1'b1;
    bus.inc  = 1'b1;
    #1;
    check("reset_immediate", bus.out, 32'h0000_0000);
    @(negedge clock);
    check("reset_held", bus.out, 32'h0000_0000);
    reset_n = 1'b1;
    drive_expect(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000);

    // 2. parallel load
    drive_expect(1'b1, 1'b0, 32'h0000_AAA0, 32'h0000_AAA0);
    // 3. increments
    drive_expect(1'b0, 1'b1, 32'h0, 32'h0000_AAA4);
    drive_expect(1'b0, 1'b1, 32'h0, 32'h0000_AAA8);
    drive_expect(1'b0, 1'b1, 32'h0, 32'h0000_AAAC);
    drive_expect(1'b0, 1'b1, 32'h0, 32'h0000_AAB0);
    // 4. load wins over inc
    drive_expect(1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678);
    // 5. wrap-around
    drive_expect(1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    drive_expect(1'b0, 1'b1, 32'h0, 32'h0000_0000);
    // 6. hold for five edges, inputs on in must be ignored
    drive_expect(1'b1, 1'b0, 32'h0000_AAA0, 32'h0000_AAA0);
    for (int i = 0; i < 5; i++)
      drive_expect(1'b0, 1'b0, 32'(($urandom)), 32'h0000_AAA0);
    drain(10);

    // mid-cycle async reset: out clears before the next rising edge
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_mid_cycle", bus.out, 32'h0000_0000);
    model_value = '0;
    @(negedge clock);
    reset_n = 1'b1;

    // randomized traffic against the reference model, biased toward the wrap boundary
    for (int i = 0; i < 300; i++) begin
      ld  = ($urandom_range(0, 3) == 0);
      ic  = ($urandom_range(0, 1) == 1);
      din = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (32'($urandom) & 32'h0000_000C))
                                        : 32'($urandom);
      drive_cycle(ld, ic, din);
    end
    drain(10);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Absolute time limit so the run always ends with a summary.
  initial begin
    #200000;
    checks_total++;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
